// File: rtl/bcd_pkg.sv
// bcd_pkg
//   Shared definitions for the iterative binary-to-BCD converter:
//   - state_t    : converter FSM states (IDLE / SHIFT / DONE)
//   - DIGIT_DASH : digit code the 7-segment scan driver renders as '-'
//   - max_dec()  : largest decimal value representable in a given digit count
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Shown on every digit when the value does not fit in the display.
  localparam logic [3:0] DIGIT_DASH = 4'hF;

  // 10**ndig - 1, evaluated at elaboration time.
  function automatic int max_dec(input int ndig);
    int r;
    r = 1;
    for (int i = 0; i < ndig; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// bcd_adj3
//   Double-dabble nibble correction: a BCD nibble of 5 or more gets 3 added
//   before the next left shift so that the shift carries into the next decade.
//   The addition is 4-bit with no carry out; inputs above 9 only occur for
//   values that are masked as overflow anyway.
// Ports
//   nib : in  4  BCD nibble before correction
//   adj : out 4  corrected nibble
module bcd_adj3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  // Add-3 correction for nibbles that would exceed 9 after doubling.
  always_comb begin
    adj = nib;
    if (nib >= 4'd5) begin
      adj = nib + 4'd3;
    end else begin
      adj = nib;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Iterative (double-dabble) binary-to-BCD converter for the 7-segment scan
//   driver. One unsigned value is accepted per valid/ready handshake and is
//   converted one bit per clock (BIN_W shift cycles), followed by one DONE
//   cycle that loads the held output digits and pulses out_valid.
//   Values above 10**NDIG-1 show all digits as DIGIT_DASH and raise overflow.
//   The digit outputs only change at the DONE edge so the scan driver, which
//   samples them on its own slow clock, never sees partial shift results.
// Parameters
//   BIN_W : width of in_bin and number of shift cycles per conversion
//   NDIG  : number of BCD digits (digit 0 = ones)
// Ports
//   clk       : in  1        system clock
//   rstn      : in  1        asynchronous active-low reset
//   in_valid  : in  1        in_bin valid this cycle
//   in_ready  : out 1        converter idle and able to accept a value
//   in_bin    : in  BIN_W    unsigned binary value to convert
//   out_valid : out 1        one-cycle pulse, new digits just loaded
//   overflow  : out 1        held, last accepted value was out of range
//   digits    : out 4*NDIG   held BCD digits, digit i at [4i+3:4i]
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 10,
  parameter int NDIG  = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BIN_W-1:0]  in_bin,
  output logic              out_valid,
  output logic              overflow,
  output logic [4*NDIG-1:0] digits
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * NDIG;
  localparam int CAT_W = BCD_W + BIN_W;
  localparam logic [31:0] MAX_VAL = 32'(max_dec(NDIG));

  state_t             state_r;
  logic [BIN_W-1:0]   shift_r;
  logic [BCD_W-1:0]   bcd_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ovf_pend_r;
  logic [BCD_W-1:0]   digits_r;
  logic               overflow_r;
  logic               out_valid_r;

  logic [BCD_W-1:0]   bcd_adj_s;
  logic [CAT_W-1:0]   cat_s;
  logic [CAT_W-1:0]   cat_shl_s;
  logic               ovf_s;

  // One add-3 corrector per decade of the working BCD register.
  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_adj3 u_adj3 (
      .nib (bcd_r[4*g +: 4]),
      .adj (bcd_adj_s[4*g +: 4])
    );
  end

  // Next shift value ({corrected bcd, binary} << 1) and range check of the input.
  // The bit shifted out of the top of the BCD register is only ever nonzero
  // for out-of-range inputs, whose result is replaced by dashes.
  always_comb begin
    cat_s     = {bcd_adj_s, shift_r};
    cat_shl_s = cat_s << 1'b1;
    ovf_s     = (32'(in_bin) > MAX_VAL);
  end

  // Converter FSM with bit counter, working registers and held outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      shift_r     <= {BIN_W{1'b0}};
      bcd_r       <= {BCD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      ovf_pend_r  <= 1'b0;
      digits_r    <= {BCD_W{1'b0}};
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (in_valid) begin
            shift_r    <= in_bin;
            bcd_r      <= {BCD_W{1'b0}};
            cnt_r      <= CNT_W'(BIN_W);
            ovf_pend_r <= ovf_s;
            state_r    <= SHIFT;
          end else begin
            state_r    <= IDLE;
          end
        end
        SHIFT: begin
          out_valid_r      <= 1'b0;
          {bcd_r, shift_r} <= cat_shl_s;
          cnt_r            <= cnt_r - CNT_W'(1);
          // Counter value 1 marks the last of the BIN_W shift edges.
          if (cnt_r == CNT_W'(1)) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          digits_r    <= ovf_pend_r ? {NDIG{DIGIT_DASH}} : bcd_r;
          overflow_r  <= ovf_pend_r;
          out_valid_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Ready is a decode of the state register so a new value can be captured
  // in the same cycle that out_valid is high.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign overflow  = overflow_r;
  assign digits    = digits_r;

endmodule
